// File: rtl/matrix_result_streamer.sv
// Captures an N x N result matrix on a valid pulse and streams it row-major on a valid/ready byte port.
// Optional second holding buffer: define MATRIX_RESULT_STREAMER_DBUF_EN.
//
// state   | meaning
// S_IDLE  | no matrix held, o_valid low, waiting for i_validResult
// S_STREAM| matrix held, presenting hold[row][col] until the last element transfers
module matrix_result_streamer #(
   parameter int N          = 4,
   parameter int W          = 8,
   parameter int DROP_CNT_W = 8
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic signed [N-1:0][N-1:0][W-1:0]     i_c,
   input  logic                                  i_validResult,
   output logic        [W-1:0]                   o_data,
   output logic                                  o_valid,
   input  logic                                  i_ready,
   output logic                                  o_last,
   output logic                                  o_busy,
   output logic                                  o_overflow,
   output logic        [DROP_CNT_W-1:0]          o_dropCount
);

   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t                        state_q;
   logic [N-1:0][N-1:0][W-1:0]    hold_q;
   logic [RW-1:0]                 row_q, col_q;
   logic [RW-1:0]                 row_d, col_d;
   logic [W-1:0]                  data_q;
   logic                          valid_q, last_q, ovf_q;
   logic [DROP_CNT_W-1:0]         drop_q;
   logic                          xfer, final_xfer, drop_now;

`ifdef MATRIX_RESULT_STREAMER_DBUF_EN
   logic [N-1:0][N-1:0][W-1:0]    hold2_q;
   logic                          full2_q;
`endif

   assign xfer       = valid_q & i_ready;
   assign final_xfer = xfer & last_q;

`ifdef MATRIX_RESULT_STREAMER_DBUF_EN
   assign drop_now = (state_q == S_STREAM) & i_validResult & ~final_xfer & full2_q;
   assign o_busy   = (state_q == S_STREAM) | full2_q;
`else
   assign drop_now = (state_q == S_STREAM) & i_validResult & ~final_xfer;
   assign o_busy   = (state_q == S_STREAM);
`endif

   // Row-major successor of the element currently presented.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (col_q == LAST_IDX) begin
         col_d = '0;
         row_d = row_q + 1'b1;
      end else begin
         col_d = col_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
`ifdef MATRIX_RESULT_STREAMER_DBUF_EN
         hold2_q <= '0;
         full2_q <= 1'b0;
`endif
      end else begin
         ovf_q <= drop_now;
         if (drop_now && (drop_q != {DROP_CNT_W{1'b1}}))
            drop_q <= drop_q + 1'b1;

         case (state_q)
            S_IDLE: begin
               if (i_validResult) begin
                  hold_q  <= i_c;
                  row_q   <= '0;
                  col_q   <= '0;
                  data_q  <= i_c[0][0];
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
                  state_q <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (final_xfer) begin
                  row_q  <= '0;
                  col_q  <= '0;
                  last_q <= 1'b0;
`ifdef MATRIX_RESULT_STREAMER_DBUF_EN
                  if (full2_q) begin
                     hold_q  <= hold2_q;
                     data_q  <= hold2_q[0][0];
                     full2_q <= i_validResult;
                     if (i_validResult)
                        hold2_q <= i_c;
                  end else if (i_validResult) begin
                     hold_q <= i_c;
                     data_q <= i_c[0][0];
                  end else begin
                     valid_q <= 1'b0;
                     data_q  <= '0;
                     state_q <= S_IDLE;
                  end
`else
                  if (i_validResult) begin
                     hold_q <= i_c;
                     data_q <= i_c[0][0];
                  end else begin
                     valid_q <= 1'b0;
                     data_q  <= '0;
                     state_q <= S_IDLE;
                  end
`endif
               end else begin
                  if (xfer) begin
                     row_q  <= row_d;
                     col_q  <= col_d;
                     data_q <= hold_q[row_d][col_d];
                     last_q <= (row_d == LAST_IDX) && (col_d == LAST_IDX);
                  end
`ifdef MATRIX_RESULT_STREAMER_DBUF_EN
                  if (i_validResult && !full2_q) begin
                     hold2_q <= i_c;
                     full2_q <= 1'b1;
                  end
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_last      = last_q;
   assign o_overflow  = ovf_q;
   assign o_dropCount = drop_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer (N=4, W=8, single buffer): scoreboard of expected bytes
// plus a reference model of valid/busy/overflow/drop count, checked every cycle.
module tb_matrix_result_streamer;

   typedef logic [3:0][3:0][7:0] mat_t;
   typedef struct { logic [7:0] d; logic l; } elem_t;
   typedef struct { int kind; int rmode; logic [7:0] first; logic [7:0] last; } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   mat_t        cur_mat;
   logic        vres;
   logic [7:0]  o_data;
   logic        o_valid, ready, o_last, o_busy, o_overflow;
   logic [7:0]  o_dropCount;

   elem_t       sbq[$];
   int          total = 0, passed = 0;
   logic        ovf_exp = 1'b0;
   int          drop_exp = 0;
   logic        stall_prev = 1'b0;
   logic [7:0]  prev_data;
   logic        prev_last;
   int          obs_n;
   logic [7:0]  obs_first, obs_last;
   vec_t        vecs[4];

   always #5 clk = ~clk;

   matrix_result_streamer #(.N(4), .W(8), .DROP_CNT_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_c(cur_mat), .i_validResult(vres),
      .o_data(o_data), .o_valid(o_valid), .i_ready(ready), .o_last(o_last),
      .o_busy(o_busy), .o_overflow(o_overflow), .o_dropCount(o_dropCount)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic mat_t make_mat(input int kind);
      mat_t m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[r][c] = (kind == 2) ? 8'($urandom) : 8'(16 * r + c);
      if (kind == 1) begin
         m[0][0] = 8'h80;
         m[3][3] = 8'hFF;
      end
      return m;
   endfunction

   // One clock: compare outputs against the model, advance the model, then cross the edge.
   task automatic step();
      int    sz;
      logic  xfer;
      elem_t e;
      sz = sbq.size();
      chk("valid", 32'(o_valid), 32'(sz > 0));
      chk("busy", 32'(o_busy), 32'(sz > 0));
      chk("overflow", 32'(o_overflow), 32'(ovf_exp));
      chk("dropcount", 32'(o_dropCount), 32'(drop_exp));
      if (stall_prev) begin
         chk("stall_data", 32'(o_data), 32'(prev_data));
         chk("stall_last", 32'(o_last), 32'(prev_last));
      end
      xfer = (sz > 0) && ready && rst_n;
      if (xfer) begin
         e = sbq.pop_front();
         chk("data", 32'(o_data), 32'(e.d));
         chk("last", 32'(o_last), 32'(e.l));
         if (obs_n == 0) obs_first = o_data;
         obs_last = o_data;
         obs_n++;
      end
      ovf_exp = 1'b0;
      if (!rst_n) begin
         sbq.delete();
         drop_exp = 0;
      end else if (vres) begin
         if (sz == 0 || (sz == 1 && xfer)) begin
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++)
                  sbq.push_back('{cur_mat[r][c], (r == 3 && c == 3)});
         end else begin
            ovf_exp = 1'b1;
            if (drop_exp != 255) drop_exp++;
         end
      end
      stall_prev = (sz > 0) && !ready && rst_n;
      prev_data  = o_data;
      prev_last  = o_last;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input int rmode);
      int n = 0;
      while (sbq.size() > 0 && n < 200) begin
         ready = (rmode == 0) ? 1'b1 : ~ready;
         step();
         n++;
      end
      if (sbq.size() > 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
      ready = 1'b1;
      step();
   endtask

   task automatic pulse(input mat_t m);
      cur_mat = m;
      vres = 1'b1;
      step();
      vres = 1'b0;
   endtask

   initial begin
      mat_t m;
      vecs[0] = '{kind: 0, rmode: 0, first: 8'h00, last: 8'h33};
      vecs[1] = '{kind: 0, rmode: 1, first: 8'h00, last: 8'h33};
      vecs[2] = '{kind: 1, rmode: 0, first: 8'h80, last: 8'hFF};
      vecs[3] = '{kind: 1, rmode: 1, first: 8'h80, last: 8'hFF};

      rst_n = 1'b0; vres = 1'b0; ready = 1'b1; cur_mat = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_data", 32'(o_data), 32'd0);
      chk("rst_last", 32'(o_last), 32'd0);
      chk("rst_ovf", 32'(o_overflow), 32'd0);
      chk("rst_drop", 32'(o_dropCount), 32'd0);
      rst_n = 1'b1;
      step();

      for (int v = 0; v < 4; v++) begin
         obs_n = 0;
         ready = 1'b1;
         pulse(make_mat(vecs[v].kind));
         drain(vecs[v].rmode);
         chk("vec_count", 32'(obs_n), 32'd16);
         chk("vec_first", 32'(obs_first), 32'(vecs[v].first));
         chk("vec_last", 32'(obs_last), 32'(vecs[v].last));
      end

      // Result arriving at element 5 is dropped; the running stream is untouched.
      obs_n = 0;
      pulse(make_mat(0));
      while (obs_n < 5 && sbq.size() > 0) step();
      cur_mat = make_mat(2);
      vres = 1'b1;
      step();
      vres = 1'b0;
      chk("drop_pulse", 32'(o_overflow), 32'd1);
      chk("drop_one", 32'(o_dropCount), 32'd1);
      drain(0);
      chk("drop_stream_len", 32'(obs_n), 32'd16);

      // Result arriving with the final transfer streams back-to-back.
      obs_n = 0;
      pulse(make_mat(0));
      while (sbq.size() > 1) step();
      m = make_mat(2);
      cur_mat = m;
      vres = 1'b1;
      step();
      vres = 1'b0;
      chk("b2b_valid", 32'(o_valid), 32'd1);
      chk("b2b_first", 32'(o_data), 32'(m[0][0]));
      chk("b2b_drop", 32'(o_dropCount), 32'd1);
      drain(0);
      chk("b2b_len", 32'(obs_n), 32'd32);

      // Reset at element 7 abandons the stream and clears the drop counter.
      obs_n = 0;
      pulse(make_mat(0));
      while (obs_n < 7 && sbq.size() > 0) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst7_valid", 32'(o_valid), 32'd0);
      chk("rst7_busy", 32'(o_busy), 32'd0);
      chk("rst7_drop", 32'(o_dropCount), 32'd0);
      obs_n = 0;
      m = make_mat(2);
      pulse(m);
      drain(0);
      chk("rst7_new_first", 32'(obs_first), 32'(m[0][0]));

      // 300 results against a stalled stream saturate the counter.
      ready = 1'b1;
      pulse(make_mat(0));
      ready = 1'b0;
      cur_mat = make_mat(2);
      vres = 1'b1;
      for (int i = 0; i < 300; i++) step();
      vres = 1'b0;
      step();
      chk("sat_drop", 32'(o_dropCount), 32'd255);
      drain(0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
